multi_digit_counter: RTL

MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

---
 rtl/multi_digit_counter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_digit_counter.sv
// Prescaled up/down BCD counter with a multiplexed 7-segment display driver.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module multi_digit_counter #(
    parameter int DIGITS = 4,
    parameter int DIV_W  = 27,
    parameter int SEL_W  = 5,
    parameter int SCAN_W = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [SEL_W-1:0]      rate_sel,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int DIG_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TAP_W     = (DIV_W > 1) ? $clog2(DIV_W) : 1;
    localparam logic [TAP_W-1:0]     MAX_TAP  = TAP_W'(DIV_W - 1);
    localparam logic [DIG_IDX_W-1:0] LAST_DIG = DIG_IDX_W'(DIGITS - 1);

    // Active-low segment patterns, bit order g..a.
    function automatic logic [6:0] seg7(input logic [3:0] val);
        logic [6:0] pat;
        case (val)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    logic [DIV_W-1:0]     r_presc;
    logic                 r_tap_q;
    logic [4*DIGITS-1:0]  r_count;
    logic                 r_tc;
    logic [SCAN_W-1:0]    r_scan;
    logic [DIG_IDX_W-1:0] r_digit;
    logic [DIGITS-1:0]    r_an;
    logic [6:0]           r_seg;

    logic [31:0]          w_sel_ext;
    logic [TAP_W-1:0]     w_tap;
    logic                 w_tap_bit;
    logic                 w_tick;
    logic [4*DIGITS-1:0]  w_inc;
    logic [4*DIGITS-1:0]  w_dec;
    logic                 w_carry;
    logic                 w_borrow;
    logic [4*DIGITS-1:0]  w_load_clamped;
    logic [3:0]           w_cur_digit;
    logic                 w_blank;
    logic [DIGITS-1:0]    w_upper_zero;
    logic                 w_zero_acc;

    // Out-of-range selects saturate to the slowest tap.
    always_comb begin
        w_sel_ext = 32'(rate_sel);
        w_tap     = MAX_TAP;
        if (w_sel_ext < 32'(DIV_W - 1)) begin
            w_tap = TAP_W'(rate_sel);
        end
    end

    assign w_tap_bit = r_presc[w_tap];
    assign w_tick    = w_tap_bit & ~r_tap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_tap_q <= 1'b0;
        end else begin
            r_presc <= r_presc + DIV_W'(1);
            r_tap_q <= w_tap_bit;
        end
    end

    // Ripple BCD increment/decrement; the final carry/borrow flags a full wrap.
    always_comb begin
        w_inc    = r_count;
        w_dec    = r_count;
        w_carry  = 1'b1;
        w_borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] >= 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_load_clamped = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                w_load_clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    // Direction is only consulted when a step actually happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_tc    <= 1'b0;
        end else if (en && w_tick) begin
            if (up) begin
                r_count <= w_inc;
                r_tc    <= w_carry;
            end else begin
                r_count <= w_dec;
                r_tc    <= w_borrow;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan  <= '0;
            r_digit <= '0;
        end else begin
            r_scan <= r_scan + SCAN_W'(1);
            if (r_scan == {SCAN_W{1'b1}}) begin
                if (r_digit == LAST_DIG) begin
                    r_digit <= '0;
                end else begin
                    r_digit <= r_digit + DIG_IDX_W'(1);
                end
            end
        end
    end

    // w_upper_zero[i] is set when digit i and every digit above it are zero.
    always_comb begin
        w_upper_zero = '0;
        w_zero_acc   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_acc      = w_zero_acc & (r_count[4*i +: 4] == 4'd0);
            w_upper_zero[i] = w_zero_acc;
        end
    end

    always_comb begin
        w_cur_digit = 4'd0;
        w_blank     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit == DIG_IDX_W'(i)) begin
                w_cur_digit = r_count[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                w_blank = (i > 0) && w_upper_zero[i];
`else
                w_blank = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= '1;
            r_seg <= 7'b1111111;
        end else begin
            r_an  <= ~(DIGITS'(1) << r_digit);
            r_seg <= w_blank ? 7'b1111111 : seg7(w_cur_digit);
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign an    = r_an;
    assign seg   = r_seg;

endmodule
